// File: rtl/sid_pkg.sv
// Shared types and constants for the SID voice mixer slice.
package sid_pkg;

    localparam int unsigned WAVE_W     = 12;
    localparam int unsigned ENV_W      = 8;
    localparam int unsigned PROD_W     = 20;
    localparam int unsigned NUM_VOICES = 3;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StAcc,
        StDone
    } mix_state_e;

    // Offset-binary waveform to two's complement: wave - 0x800.
    function automatic logic signed [WAVE_W-1:0] wave_to_signed(input logic [WAVE_W-1:0] w);
        return {~w[WAVE_W-1], w[WAVE_W-2:0]};
    endfunction

endpackage

// File: rtl/sid_voice_mixer_if.sv
// Voice inputs and mixed-output bus between envelope generators, mixer and filter stage.
interface sid_voice_mixer_if
    import sid_pkg::*;
#(
    parameter int unsigned ACC_W = 22
) ();

    logic                     sample_tick;
    logic [WAVE_W-1:0]        wave0;
    logic [WAVE_W-1:0]        wave1;
    logic [WAVE_W-1:0]        wave2;
    logic [ENV_W-1:0]         env0;
    logic [ENV_W-1:0]         env1;
    logic [ENV_W-1:0]         env2;
    logic [NUM_VOICES-1:0]    filt_en;
    logic                     voice3_off;
    logic signed [ACC_W-1:0]  filt_out;
    logic signed [ACC_W-1:0]  direct_out;
    logic                     out_valid;
    logic                     overrun;

    modport master (
        output sample_tick, wave0, wave1, wave2, env0, env1, env2, filt_en, voice3_off,
        input  filt_out, direct_out, out_valid, overrun
    );

    modport slave (
        input  sample_tick, wave0, wave1, wave2, env0, env1, env2, filt_en, voice3_off,
        output filt_out, direct_out, out_valid, overrun
    );

endinterface

// File: rtl/sid_serial_mul.sv
// 12x8 signed-by-unsigned shift-add multiplier, one multiplier bit per clock, LSB first.
module sid_serial_mul
    import sid_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic signed [WAVE_W-1:0] a_i,
    input  logic [ENV_W-1:0]         b_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic signed [PROD_W-1:0] p_o
);

    localparam int unsigned BitW = $clog2(ENV_W);

    logic [BitW-1:0]          bit_q, bit_d;
    logic                     busy_q, busy_d;
    logic signed [PROD_W-1:0] p_q, p_d;
    logic signed [PROD_W-1:0] a_ext;

    assign a_ext = {{(PROD_W - WAVE_W){a_i[WAVE_W-1]}}, a_i};

    // Start clears the partial product; a_i/b_i must stay stable while busy.
    always_comb begin
        bit_d  = bit_q;
        busy_d = busy_q;
        p_d    = p_q;
        if (start_i) begin
            bit_d  = '0;
            busy_d = 1'b1;
            p_d    = '0;
        end else if (busy_q) begin
            if (b_i[bit_q]) begin
                p_d = p_q + (a_ext <<< bit_q);
            end
            bit_d = bit_q + 1'b1;
            if (bit_q == BitW'(ENV_W - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_q  <= '0;
            busy_q <= 1'b0;
            p_q    <= '0;
        end else begin
            bit_q  <= bit_d;
            busy_q <= busy_d;
            p_q    <= p_d;
        end
    end

    // High during the final accumulation step, so p_o is complete after this edge.
    assign done_o = busy_q && (bit_q == BitW'(ENV_W - 1));
    assign busy_o = busy_q;
    assign p_o    = p_q;

endmodule

// File: rtl/sid_voice_mixer.sv
// Snapshots three voices per sample tick, multiplies wave by envelope serially and sums
// the products onto the filter and direct buses.
module sid_voice_mixer
    import sid_pkg::*;
#(
    parameter int unsigned ACC_W = 22
) (
    input logic               clock,
    input logic               reset,
    sid_voice_mixer_if.slave  bus_io
);

    mix_state_e               state_q, state_d;
    logic [1:0]               voice_q, voice_d;
    logic [WAVE_W-1:0]        wave_q [NUM_VOICES];
    logic [WAVE_W-1:0]        wave_d [NUM_VOICES];
    logic [ENV_W-1:0]         env_q  [NUM_VOICES];
    logic [ENV_W-1:0]         env_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0]    filt_en_q, filt_en_d;
    logic                     v3_off_q, v3_off_d;
    logic signed [ACC_W-1:0]  filt_acc_q, filt_acc_d;
    logic signed [ACC_W-1:0]  dir_acc_q, dir_acc_d;
    logic signed [ACC_W-1:0]  filt_out_q, filt_out_d;
    logic signed [ACC_W-1:0]  dir_out_q, dir_out_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;

    logic                     mul_start;
    logic                     mul_busy;
    logic                     mul_done;
    logic signed [PROD_W-1:0] mul_p;
    logic signed [ACC_W-1:0]  prod_ext;

    sid_serial_mul u_mul (
        .clock   (clock),
        .reset   (reset),
        .start_i (mul_start),
        .a_i     (wave_to_signed(wave_q[voice_q])),
        .b_i     (env_q[voice_q]),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .p_o     (mul_p)
    );

    assign prod_ext = {{(ACC_W - PROD_W){mul_p[PROD_W-1]}}, mul_p};

    always_comb begin
        state_d    = state_q;
        voice_d    = voice_q;
        wave_d     = wave_q;
        env_d      = env_q;
        filt_en_d  = filt_en_q;
        v3_off_d   = v3_off_q;
        filt_acc_d = filt_acc_q;
        dir_acc_d  = dir_acc_q;
        filt_out_d = filt_out_q;
        dir_out_d  = dir_out_q;
        valid_d    = 1'b0;
        overrun_d  = bus_io.sample_tick && (state_q != StIdle);
        mul_start  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.sample_tick) begin
                    wave_d     = '{bus_io.wave0, bus_io.wave1, bus_io.wave2};
                    env_d      = '{bus_io.env0, bus_io.env1, bus_io.env2};
                    filt_en_d  = bus_io.filt_en;
                    v3_off_d   = bus_io.voice3_off;
                    voice_d    = '0;
                    filt_acc_d = '0;
                    dir_acc_d  = '0;
                    mul_start  = 1'b1;
                    state_d    = StMul;
                end
            end
            StMul: begin
                if (mul_done) begin
                    state_d = StAcc;
                end
            end
            StAcc: begin
                // voice3_off only mutes voice 2 on the direct bus, never on the filter bus.
                if (filt_en_q[voice_q]) begin
                    filt_acc_d = filt_acc_q + prod_ext;
                end else if (!(voice_q == 2'd2 && v3_off_q)) begin
                    dir_acc_d = dir_acc_q + prod_ext;
                end
                voice_d = voice_q + 2'd1;
                if (voice_q == 2'(NUM_VOICES - 1)) begin
                    state_d = StDone;
                end else begin
                    mul_start = 1'b1;
                    state_d   = StMul;
                end
            end
            StDone: begin
                filt_out_d = filt_acc_q;
                dir_out_d  = dir_acc_q;
                valid_d    = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            voice_q    <= '0;
            wave_q     <= '{default: '0};
            env_q      <= '{default: '0};
            filt_en_q  <= '0;
            v3_off_q   <= 1'b0;
            filt_acc_q <= '0;
            dir_acc_q  <= '0;
            filt_out_q <= '0;
            dir_out_q  <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            voice_q    <= voice_d;
            wave_q     <= wave_d;
            env_q      <= env_d;
            filt_en_q  <= filt_en_d;
            v3_off_q   <= v3_off_d;
            filt_acc_q <= filt_acc_d;
            dir_acc_q  <= dir_acc_d;
            filt_out_q <= filt_out_d;
            dir_out_q  <= dir_out_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus_io.filt_out   = filt_out_q;
    assign bus_io.direct_out = dir_out_q;
    assign bus_io.out_valid  = valid_q;
    assign bus_io.overrun    = overrun_q;

    logic unused_busy;
    assign unused_busy = mul_busy;

endmodule
